// File: rtl/posit_add_arbiter.sv
// Round-robin arbiter that time-shares one pipelined posit adder between NREQ requesters.
// Requester IDs ride a tag pipeline matched to the adder latency and tag each returned result.
module posit_add_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 4
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_in1,
    input  logic [NREQ*N-1:0] req_in2,
    output logic [NREQ-1:0]   req_ready,
    output logic [N-1:0]      add_in1,
    output logic [N-1:0]      add_in2,
    output logic              add_start,
    input  logic [N-1:0]      add_result,
    input  logic              add_inf,
    input  logic              add_zero,
    input  logic              add_done,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic [N-1:0]      res_data,
    output logic              res_inf,
    output logic              res_zero,
    output logic              busy,
    output logic              err_sync
);

    localparam int GW = $clog2(LAT + 1);

    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] issue_id_r;
    logic [IDW-1:0] grant_id_s;
    logic           found_s;
    logic           grant_ok_s;
    logic           hs_s;
    logic [GW-1:0]  guard_r;
    logic           guard_zero_s;
    logic [LAT-1:0] tag_v_r;
    logic [IDW-1:0] tag_id_r [LAT];
    logic           tail_v_s;
    logic [IDW-1:0] tail_id_s;
    logic           err_sync_r;

    assign guard_zero_s = (guard_r == '0);
    // The adder has no reset, so the guard window also blocks grants while stale pulses drain.
    assign grant_ok_s   = en & ~reset & guard_zero_s;
    assign hs_s         = grant_ok_s & found_s;
    assign tail_v_s     = tag_v_r[LAT-1];
    assign tail_id_s    = tag_id_r[LAT-1];

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin : grant_search
        logic [IDW:0] sum_v;
        found_s    = 1'b0;
        grant_id_s = '0;
        sum_v      = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_v = {1'b0, ptr_r} + (IDW+1)'(k);
            if (sum_v >= (IDW+1)'(NREQ)) begin
                sum_v = sum_v - (IDW+1)'(NREQ);
            end else begin
                sum_v = sum_v;
            end
            if (!found_s && req_valid[sum_v[IDW-1:0]]) begin
                found_s    = 1'b1;
                grant_id_s = sum_v[IDW-1:0];
            end else begin
                found_s    = found_s;
            end
        end
    end

    // One-hot grant vector, gated so it never depends on operand data.
    always_comb begin
        req_ready = '0;
        if (hs_s) begin
            req_ready = NREQ'(1) << grant_id_s;
        end else begin
            req_ready = '0;
        end
    end

    // Issue register and round-robin pointer.
    always_ff @(posedge aclk) begin
        if (reset) begin
            ptr_r      <= '0;
            add_start  <= 1'b0;
            add_in1    <= '0;
            add_in2    <= '0;
            issue_id_r <= '0;
        end else if (hs_s) begin
            ptr_r      <= (grant_id_s == IDW'(NREQ - 1)) ? '0 : grant_id_s + IDW'(1);
            add_start  <= 1'b1;
            add_in1    <= req_in1[grant_id_s*N +: N];
            add_in2    <= req_in2[grant_id_s*N +: N];
            issue_id_r <= grant_id_s;
        end else begin
            add_start  <= 1'b0;
        end
    end

    // Tag pipeline: tail lines up with add_done LAT cycles after add_start.
    always_ff @(posedge aclk) begin
        if (reset) begin
            tag_v_r <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id_r[i] <= '0;
            end
        end else begin
            tag_v_r[0]  <= add_start;
            tag_id_r[0] <= issue_id_r;
            for (int i = 1; i < LAT; i++) begin
                tag_v_r[i]  <= tag_v_r[i-1];
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    // Guard counter: reloaded by reset, counts down to zero.
    always_ff @(posedge aclk) begin
        if (reset) begin
            guard_r <= GW'(LAT);
        end else if (!guard_zero_s) begin
            guard_r <= guard_r - GW'(1);
        end else begin
            guard_r <= guard_r;
        end
    end

    // Sticky sync-error flag: adder done disagreeing with the tag tail.
    always_ff @(posedge aclk) begin
        if (reset) begin
            err_sync_r <= 1'b0;
        end else if (guard_zero_s && (add_done != tail_v_s)) begin
            err_sync_r <= 1'b1;
        end else begin
            err_sync_r <= err_sync_r;
        end
    end

    assign res_valid = add_done & tail_v_s & guard_zero_s & ~reset;
    assign res_id    = tail_id_s;
    assign res_data  = reset ? '0 : add_result;
    assign res_inf   = add_inf;
    assign res_zero  = add_zero;
    assign busy      = add_start | (|tag_v_r);
    assign err_sync  = err_sync_r;

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Bench for posit_add_arbiter: emulated adder, directed phases plus random traffic,
// all outputs checked every cycle against a queue-based scoreboard.
module tb_posit_add_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 4;

    logic              aclk = 1'b0;
    logic              reset;
    logic              en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_in1;
    logic [NREQ*N-1:0] req_in2;
    logic [NREQ-1:0]   req_ready;
    logic [N-1:0]      add_in1;
    logic [N-1:0]      add_in2;
    logic              add_start;
    logic [N-1:0]      add_result;
    logic              add_inf;
    logic              add_zero;
    logic              add_done;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [N-1:0]      res_data;
    logic              res_inf;
    logic              res_zero;
    logic              busy;
    logic              err_sync;

    posit_add_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
        .aclk(aclk), .reset(reset), .en(en),
        .req_valid(req_valid), .req_in1(req_in1), .req_in2(req_in2), .req_ready(req_ready),
        .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
        .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .res_inf(res_inf), .res_zero(res_zero), .busy(busy), .err_sync(err_sync)
    );

    always #5 aclk = ~aclk;

    // Stand-in adder: integer sum after LAT cycles, no reset, optional injected done.
    logic [LAT-1:0] pv = '0;
    logic [N-1:0]   pd [LAT];
    logic           inject = 1'b0;

    always @(posedge aclk) begin
        pv    <= {pv[LAT-2:0], (add_start === 1'b1)};
        pd[0] <= add_in1 + add_in2;
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end

    assign add_done   = pv[LAT-1] | inject;
    assign add_result = pd[LAT-1];
    assign add_zero   = (add_result == 32'h0000_0000);
    assign add_inf    = (add_result == 32'h8000_0000);

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          m_guard = LAT;
    int          m_ptr = 0;
    logic        m_err = 1'b0;
    int          last_grant = -1;
    logic [3:0]  obs_ready;
    logic        pend [NREQ];
    logic [31:0] op1 [NREQ];
    logic [31:0] op2 [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        int          g;
        int          i;
        logic        due_now;
        logic        exp_busy;
        logic        done_s;
        logic [3:0]  exp_ready;
        logic [31:0] d;
        @(negedge aclk);
        g = -1;
        if (en && !reset && m_guard == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[i]) g = i;
            end
        end
        exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        obs_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        due_now  = (q.size() > 0) && (q[0].due == cyc);
        exp_busy = 1'b0;
        foreach (q[j]) if (q[j].due - LAT <= cyc) exp_busy = 1'b1;
        chk("res_valid", 32'(res_valid), 32'(due_now && !reset));
        if (due_now && !reset) begin
            d = q[0].data;
            chk("res_id", 32'(res_id), 32'(q[0].id));
            chk("res_data", res_data, d);
            chk("res_zero", 32'(res_zero), 32'(d == 32'h0000_0000));
            chk("res_inf", 32'(res_inf), 32'(d == 32'h8000_0000));
        end
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("err_sync", 32'(err_sync), 32'(m_err));
        done_s = add_done;
        @(posedge aclk);
        if (reset) begin
            m_guard = LAT;
            m_ptr   = 0;
            m_err   = 1'b0;
            q.delete();
        end else begin
            if (m_guard == 0 && done_s !== due_now) m_err = 1'b1;
            if (due_now) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{id: g, data: req_in1[g*N +: N] + req_in2[g*N +: N], due: cyc + 1 + LAT});
                m_ptr = (g + 1) % NREQ;
            end
            if (m_guard > 0) m_guard--;
        end
        cyc++;
        last_grant = g;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b);
        req_in1[r*N +: N] = a;
        req_in2[r*N +: N] = b;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; req_valid = '0; req_in1 = '0; req_in2 = '0;

        // Reset, guard window, then round-robin over all four requesters
        ticks(2);
        reset = 1'b0;
        for (int r = 0; r < NREQ; r++) set_ops(r, 32'h4000_0000, 32'h0000_0000);
        req_valid = 4'b1111;
        ticks(4);
        tick();
        chk("first_grant", 32'(obs_ready), 32'h0000_0001);
        ticks(4);
        req_valid = 4'b0000;
        ticks(8);

        // Pointer skip and wrap, zero-operand op on requester 2
        reset = 1'b1; tick(); reset = 1'b0;
        ticks(LAT);
        set_ops(1, 32'h1234_5678, 32'h0000_0001);
        set_ops(2, 32'h0000_0000, 32'h0000_0000);
        set_ops(3, 32'h0f0f_0f0f, 32'h1010_1010);
        req_valid = 4'b1010; ticks(2);
        req_valid = 4'b0100; ticks(1);
        req_valid = 4'b1010; ticks(3);
        req_valid = 4'b0000; ticks(8);

        // Infinity flag
        set_ops(0, 32'h7fff_ffff, 32'h0000_0001);
        req_valid = 4'b0001; ticks(1);
        req_valid = 4'b0000; ticks(7);

        // en dropped with ops in flight and requests pending
        for (int r = 0; r < NREQ; r++) set_ops(r, $urandom, $urandom);
        req_valid = 4'b1111; ticks(3);
        en = 1'b0; ticks(10);
        en = 1'b1; req_valid = 4'b0000; ticks(2);

        // Reset with three ops in flight
        req_valid = 4'b1111; ticks(3);
        req_valid = 4'b0000; reset = 1'b1; tick(); reset = 1'b0;
        ticks(LAT + 6);

        // Injected done with an empty tail
        inject = 1'b1; tick(); inject = 1'b0;
        ticks(1);
        chk("err_set", 32'(err_sync), 32'h0000_0001);
        ticks(4);
        chk("err_sticky", 32'(err_sync), 32'h0000_0001);
        reset = 1'b1; tick(); reset = 1'b0;
        ticks(LAT);

        // Random traffic; requesters hold operands until their handshake
        for (int r = 0; r < NREQ; r++) pend[r] = 1'b0;
        for (int t = 0; t < 400; t++) begin
            en = ($urandom_range(0, 7) != 0);
            for (int r = 0; r < NREQ; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    op1[r]  = $urandom;
                    case ($urandom_range(0, 5))
                        0:       op2[r] = 32'h8000_0000 - op1[r];
                        1:       op2[r] = 32'h0000_0000 - op1[r];
                        default: op2[r] = $urandom;
                    endcase
                end
                req_valid[r] = pend[r];
                set_ops(r, op1[r], op2[r]);
            end
            tick();
            if (last_grant >= 0) pend[last_grant] = 1'b0;
        end
        en = 1'b1; req_valid = 4'b0000;
        ticks(LAT + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
